sevenseg_scan: RTL and testbench

SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

---
 rtl/sevenseg_scan.sv | 97 +++++++++
 tb/tb_sevenseg_scan.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// Four-digit multiplexed BCD display scanner with a valid/ready load port.
// New values are double-buffered and swapped in only at a frame boundary.
module sevenseg_scan #(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  input  logic        blank_lz,
  output logic [3:0]  digit_data,
  output logic [3:0]  anode,
  output logic        frame_done,
  output logic        err
);

  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   disp;
  logic [15:0]   pend;
  logic          pend_v;

  logic tick;
  logic wrap;
  logic accept;

  function automatic logic has_non_bcd(input logic [15:0] d);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (d[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign tick     = (cnt == CNT_MAX);
  assign wrap     = tick && (idx == 2'd3);
  assign in_ready = !pend_v && !reset;
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state is written with <= only, so every register in this
  // block sees the pre-edge value of every other one regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      disp       <= 16'h0000;
      pend_v     <= 1'b0;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      frame_done <= wrap;
      if (tick) idx <= idx + 2'd1;
      // A frame-wrap swap needs pend_v set, an accept needs it clear, so the
      // two never fight over pend_v on the same edge.
      if (wrap && pend_v) begin
        disp   <= pend;
        pend_v <= 1'b0;
      end
      if (accept) begin
        pend_v <= 1'b1;
        if (has_non_bcd(in_data)) err <= 1'b1;
      end
    end
  end

  // NOTE: the pending payload has no reset; pend_v alone says whether it is
  // meaningful, which keeps the data path free of reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) pend <= in_data;
  end

  logic [3:0] cur;
  logic       upper_zero;

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    cur        = disp[{idx, 2'b00} +: 4];
    upper_zero = 1'b0;
    case (idx)
      2'd1:    upper_zero = (disp[15:4]  == 12'h000);
      2'd2:    upper_zero = (disp[15:8]  == 8'h00);
      2'd3:    upper_zero = (disp[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
    digit_data = (blank_lz && upper_zero) ? 4'hF : cur;
  end

  assign anode = 4'b0001 << idx;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan: directed scenarios plus a random
// phase, compared every cycle against a time-based reference model.
module tb_sevenseg_scan;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        blank_lz = 1'b0;
  logic        in_ready, frame_done, err;
  logic [3:0]  digit_data, anode;
  logic        in_ready1, frame_done1, err1;
  logic [3:0]  digit_data1, anode1;

  sevenseg_scan #(.DIV(DIV)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .blank_lz(blank_lz), .digit_data(digit_data),
    .anode(anode), .frame_done(frame_done), .err(err)
  );

  sevenseg_scan #(.DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .blank_lz(blank_lz), .digit_data(digit_data1),
    .anode(anode1), .frame_done(frame_done1), .err(err1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: position in the scan is derived from elapsed cycles.
  int          t = 0;
  logic [15:0] m_disp = 16'h0000;
  logic [15:0] m_pend = 16'h0000;
  logic        m_pend_v = 1'b0;
  logic        m_err = 1'b0;
  logic        m_fd = 1'b0;
  logic        model_ok = 1'b0;
  logic [15:0] shown[$];

  function automatic logic non_bcd(input logic [15:0] d);
    for (int i = 0; i < 4; i++) if (((d >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_digit(input logic [15:0] d, input int i, input logic bl);
    logic [15:0] upper;
    upper = d >> (4 * i);
    if (bl && i >= 1 && upper == 16'h0000) return 4'hF;
    return upper[3:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic step();
    int pos;
    #1;
    if (model_ok) begin
      pos = (t / DIV) % 4;
      check("anode", {28'd0, anode}, {28'd0, 4'b0001 << pos});
      check("digit_data", {28'd0, digit_data}, {28'd0, exp_digit(m_disp, pos, blank_lz)});
      check("in_ready", {31'd0, in_ready}, {31'd0, !m_pend_v && !reset});
      check("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
      check("err", {31'd0, err}, {31'd0, m_err});
      check("anode_div1", {28'd0, anode1}, {28'd0, 4'b0001 << (t % 4)});
      check("frame_done_div1", {31'd0, frame_done1}, {31'd0, t > 0 && t % 4 == 0});
    end
    @(posedge clk);
    if (reset) begin
      t = 0; m_disp = 16'h0000; m_pend_v = 1'b0; m_err = 1'b0; m_fd = 1'b0;
      model_ok = 1'b1;
    end else begin
      logic wrap, acc;
      wrap = ((t + 1) % (4 * DIV)) == 0;
      acc  = in_valid && !m_pend_v;
      m_fd = wrap;
      if (wrap && m_pend_v) begin
        m_disp = m_pend; m_pend_v = 1'b0; shown.push_back(m_disp);
      end
      if (acc) begin
        m_pend = in_data; m_pend_v = 1'b1;
        if (non_bcd(in_data)) m_err = 1'b1;
      end
      t++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; in_valid = 1'b0;
    idle(n);
    reset = 1'b0;
  endtask

  // Offers d and holds it until the model says it was taken.
  task automatic send(input logic [15:0] d);
    logic taken;
    taken = 1'b0;
    in_valid = 1'b1; in_data = d;
    for (int i = 0; i < 8 * DIV + 4 && !taken; i++) begin
      taken = !m_pend_v && !reset;
      step();
    end
    in_valid = 1'b0;
    if (!taken) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=not_accepted expected=%0h_accepted", d);
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset(2);
    // Idle scan: rotation, frame_done at cycle 16, zeros throughout.
    idle(20);

    do_reset(1);
    idle(2);
    send(16'h1234);
    idle(40);

    do_reset(1);
    blank_lz = 1'b1;
    send(16'h0070);
    idle(4 * DIV * 2 + 2);
    blank_lz = 1'b0;
    idle(3);
    blank_lz = 1'b1;
    idle(4 * DIV + 2);

    send(16'h00A5);
    idle(4 * DIV * 2);
    check("err_sticky", {31'd0, err}, 32'd1);
    do_reset(1);
    idle(2);
    check("err_cleared", {31'd0, err}, 32'd0);

    shown.delete();
    send(16'h1111);
    send(16'h2222);
    idle(4 * DIV * 3);
    check("shown_count", shown.size(), 32'd2);
    if (shown.size() == 2) begin
      check("shown_first", {16'd0, shown[0]}, 32'h1111);
      check("shown_second", {16'd0, shown[1]}, 32'h2222);
    end

    do_reset(1);
    idle(2);
    send(16'h9876);
    idle(3);
    reset = 1'b1; in_valid = 1'b1; in_data = 16'h5555;
    step();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("post_reset_anode", {28'd0, anode}, 32'h1);
    check("post_reset_ready", {31'd0, in_ready}, 32'd1);
    idle(4 * DIV * 2);

    for (int i = 0; i < 600; i++) begin
      logic [15:0] d;
      for (int k = 0; k < 4; k++) d[4*k +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) d = 16'($urandom);
      in_data  = d;
      in_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      reset    = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0; in_valid = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
